// File: rtl/snake_dir_ctrl_if.sv
// Command/status bundle between the player input front end and the snake
// movement controller; the controller takes the slave side.
interface snake_dir_ctrl_if #(
    parameter int SPEED_STEPS = 4
);
    localparam int SW = (SPEED_STEPS > 1) ? $clog2(SPEED_STEPS) : 1;

    logic          btn_up;
    logic          btn_down;
    logic          btn_left;
    logic          btn_right;
    logic          btn_pause;
    logic          speed_up;
    logic [2:0]    accion;
    logic          move;
    logic          paused;
    logic [1:0]    state;
    logic [SW-1:0] speed_lvl;
    logic          q_overflow;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_pause, speed_up,
        input  accion, move, paused, state, speed_lvl, q_overflow
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_pause, speed_up,
        output accion, move, paused, state, speed_lvl, q_overflow
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake movement controller: queues player commands, generates a speed-scaled
// movement tick and runs the direction/pause FSM once per tick.
module snake_dir_ctrl #(
    parameter int TICK_BASE     = 4000000,
    parameter int SPEED_DEC     = 500000,
    parameter int SPEED_STEPS   = 4,
    parameter int QDEPTH        = 4,
    parameter int ALLOW_REVERSE = 0
) (
    input  logic            clk,
    input  logic            rst,
    snake_dir_ctrl_if.slave bus
);
    localparam int CW = $clog2(TICK_BASE + 1);
    localparam int SW = (SPEED_STEPS > 1) ? $clog2(SPEED_STEPS) : 1;
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int NW = $clog2(QDEPTH + 1);

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_UP    = 3'd1;
    localparam logic [2:0] CMD_DOWN  = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_PAUSE = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    logic [CW-1:0] cnt_q, cnt_d, per_q, per_d;
    logic [2:0]    cmd_q, cmd_d;
    logic [2:0]    mem_q [QDEPTH];
    logic [2:0]    mem_d [QDEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [NW-1:0] num_q, num_d;
    state_e        state_q, state_d;
    logic [2:0]    dir_q, dir_d, accion_q, accion_d;
    logic          move_q, move_d, paused_q, paused_d, ovf_q, ovf_d;
    logic [SW-1:0] speed_q, speed_d;

    logic       tick, q_empty, q_full, pop, bypass, push;
    logic [2:0] cmd_c;

    // Up/down share (code-1)>>1 == 0, left/right share (code-1)>>1 == 1.
    function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
        return (a != b) && (((a - 3'd1) >> 1) == ((b - 3'd1) >> 1));
    endfunction

    always_comb begin
        cnt_d    = cnt_q;
        per_d    = per_q;
        cmd_d    = CMD_NONE;
        mem_d    = mem_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        num_d    = num_q;
        state_d  = state_q;
        dir_d    = dir_q;
        accion_d = accion_q;
        paused_d = paused_q;
        ovf_d    = ovf_q;
        speed_d  = speed_q;

        if      (bus.btn_pause) cmd_d = CMD_PAUSE;
        else if (bus.btn_up)    cmd_d = CMD_UP;
        else if (bus.btn_down)  cmd_d = CMD_DOWN;
        else if (bus.btn_left)  cmd_d = CMD_LEFT;
        else if (bus.btn_right) cmd_d = CMD_RIGHT;

        tick = (cnt_q == per_q - CW'(1));
        if (tick) begin
            cnt_d = '0;
            per_d = CW'(TICK_BASE - SPEED_DEC * int'(speed_q));
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        move_d = tick;

        if (bus.speed_up && speed_q != SW'(SPEED_STEPS - 1))
            speed_d = speed_q + SW'(1);

        // An empty queue forwards the command being enqueued this edge to the tick.
        q_empty = (num_q == '0);
        q_full  = (num_q == NW'(QDEPTH));
        cmd_c   = q_empty ? cmd_q : mem_q[rd_q];
        pop     = tick && !q_empty;
        bypass  = tick && q_empty && (cmd_q != CMD_NONE);
        push    = (cmd_q != CMD_NONE) && !bypass;

        if (pop) begin
            rd_d  = (rd_q == AW'(QDEPTH - 1)) ? '0 : rd_q + AW'(1);
            num_d = num_q - NW'(1);
        end
        if (push) begin
            if (q_full && !pop) begin
                ovf_d = 1'b1;
            end else begin
                mem_d[wr_q] = cmd_q;
                wr_d        = (wr_q == AW'(QDEPTH - 1)) ? '0 : wr_q + AW'(1);
                num_d       = pop ? num_q : num_q + NW'(1);
            end
        end

        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_c >= CMD_UP && cmd_c <= CMD_RIGHT) begin
                        state_d  = ST_MOVE;
                        dir_d    = cmd_c;
                        accion_d = cmd_c;
                    end else begin
                        accion_d = CMD_NONE;
                    end
                end
                ST_MOVE: begin
                    if (cmd_c == CMD_PAUSE) begin
                        state_d  = ST_PAUSED;
                        accion_d = CMD_NONE;
                    end else if (cmd_c >= CMD_UP && cmd_c <= CMD_RIGHT &&
                                 (ALLOW_REVERSE != 0 || !is_opposite(cmd_c, dir_q))) begin
                        dir_d    = cmd_c;
                        accion_d = cmd_c;
                    end else begin
                        accion_d = dir_q;
                    end
                end
                ST_PAUSED: begin
                    if (cmd_c == CMD_PAUSE) begin
                        state_d  = ST_MOVE;
                        accion_d = dir_q;
                    end else begin
                        accion_d = CMD_NONE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    accion_d = CMD_NONE;
                end
            endcase
            paused_d = (state_d == ST_PAUSED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            per_q    <= CW'(TICK_BASE);
            cmd_q    <= CMD_NONE;
            for (int unsigned i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            num_q    <= '0;
            state_q  <= ST_IDLE;
            dir_q    <= CMD_RIGHT;
            accion_q <= CMD_NONE;
            move_q   <= 1'b0;
            paused_q <= 1'b0;
            ovf_q    <= 1'b0;
            speed_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            cmd_q    <= cmd_d;
            mem_q    <= mem_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            num_q    <= num_d;
            state_q  <= state_d;
            dir_q    <= dir_d;
            accion_q <= accion_d;
            move_q   <= move_d;
            paused_q <= paused_d;
            ovf_q    <= ovf_d;
            speed_q  <= speed_d;
        end
    end

    assign bus.accion     = accion_q;
    assign bus.move       = move_q;
    assign bus.paused     = paused_q;
    assign bus.state      = state_q;
    assign bus.speed_lvl  = speed_q;
    assign bus.q_overflow = ovf_q;
endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Parametrised movement controller for the snake game. It queues one-cycle player commands, generates the movement tick with a selectable speed level, and runs the direction/pause state machine once per tick. It drives `accion` and the `move` strobe into the game-logic block, replacing the fixed-period, single-slot direction FSM. New behaviour:

- configurable command queue depth
- speed levels that shorten the tick period
- optional reversal rejection
- queue overflow flag

## Interface

Parameters:

- TICK_BASE, 4000000: tick period in clk cycles at speed level 0
- SPEED_DEC, 500000: cycles removed from the period per speed level
- SPEED_STEPS, 4: number of speed levels. Must satisfy TICK_BASE > (SPEED_STEPS-1)*SPEED_DEC.
- QDEPTH, 4: command queue depth in entries. Minimum 1; need not be a power of 2.
- ALLOW_REVERSE, 0: 1 lets opposite-direction commands take effect; 0 discards them.

Ports:

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_up, btn_down, btn_left, btn_right, btn_pause  in  1 each  one-cycle command pulses, already debounced
- speed_up  in  1  one-cycle pulse that raises the speed level by one (driven from `comer`)
- accion  out  3  0 = none, 1 = up, 2 = down, 3 = left, 4 = right
- move  out  1  one-cycle strobe marking a movement step
- paused  out  1  high while in PAUSED
- state  out  2  0 = IDLE, 1 = MOVE, 2 = PAUSED
- speed_lvl  out  $clog2(SPEED_STEPS)  current speed level
- q_overflow  out  1  sticky; set when a command is dropped because the queue is full

## Operation

Command encode:

- Command codes: 1 = up, 2 = down, 3 = left, 4 = right, 5 = pause.
- If several buttons are high in the same cycle, only one is encoded, with priority pause > up > down > left > right.
- Cycles with no button produce no enqueue; code 0 is never stored.

Queue:

- FIFO of QDEPTH 3-bit entries.
- Push when full: the command is dropped and q_overflow is set. q_overflow stays set until rst.
- Push and pop in the same cycle while full: both happen; no drop.
- Pop happens only on a tick. An empty queue yields c = 0.

Tick generator:

- The counter counts 0 to P-1, where P = TICK_BASE - speed_lvl*SPEED_DEC.
- The tick fires when the counter equals P-1; the counter then returns to 0.
- P is latched at each wrap, so a speed_up only shortens the following period.
- speed_lvl saturates at SPEED_STEPS-1.

FSM (evaluated on a tick with popped command c; `dir` is an internal register):

- IDLE:
  - c in 1..4: go to MOVE, set dir = c, accion = c.
  - Otherwise: stay in IDLE, accion = 0.
- MOVE:
  - c = 0: keep dir, accion = dir.
  - c perpendicular to dir: set dir = c.
  - c equal to dir: no change.
  - c opposite to dir: set dir = c if ALLOW_REVERSE = 1, else discard.
  - In all three direction cases, accion = dir after any update.
  - c = 5: go to PAUSED, accion = 0.
- PAUSED:
  - c = 5: go to MOVE, accion = dir (direction is restored).
  - Any other c is popped and discarded; accion = 0.

move pulses on every tick in every state; accion = 0 means no displacement.

Reset clears:

- counter = 0, P = TICK_BASE, state = IDLE, dir = 4, accion = 0
- move = 0, paused = 0, speed_lvl = 0, queue empty, q_overflow = 0

Reset applied mid-period or mid-pause returns every item above to these values on the next edge. Pending commands are lost.

## Timing

- A command pulse at edge k is enqueued at edge k+1 and can be popped by a tick at edge k+1 or later.
- For the tick condition evaluated at edge T: accion, state, paused and dir update at T, and move is high for exactly the cycle after T.
- The first tick after rst is released falls P edges later, which is TICK_BASE at speed level 0.
- speed_up pulses arriving in the same period accumulate, each incrementing speed_lvl one cycle after it arrives.
- Outputs are registered with no combinational path from inputs. Output latency from a command is at most one full tick period plus QDEPTH-1 further periods.

## Test plan

Parameters for all scenarios: TICK_BASE = 10, SPEED_DEC = 2, SPEED_STEPS = 4, QDEPTH = 2, ALLOW_REVERSE = 0.

1. Release rst, then pulse btn_right at cycle 2 -> move high on cycle 10 with accion = 4 and state = 1; move is low on all other cycles; the next move is 10 cycles later with accion = 4.
2. In MOVE right, pulse btn_left, then btn_up before the next tick -> the first tick keeps accion = 4 (left is discarded); the second tick gives accion = 1.
3. Pulse btn_pause -> the next tick gives accion = 0, paused = 1, state = 2. Then pulse btn_down, then btn_pause -> the down command is discarded, and the following tick resumes with accion = 1.
4. Pulse up, left, down on three consecutive cycles with the queue empty -> down is dropped and q_overflow = 1; q_overflow stays 1 until rst.
5. Pulse speed_up 5 times -> speed_lvl saturates at 3; tick spacing goes 10, then 4 from the next wrap onward.
6. Pulse btn_up and btn_pause in the same cycle while in MOVE -> only pause is queued. Asserting rst mid-period -> accion = 0, state = 0, queue empty, and the next move occurs 10 cycles after release.
